push_button_bank: RTL and testbench



---
 rtl/push_button_bank.sv | 130 +++++++++++++
 tb/tb_push_button_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/push_button_bank.sv
// N-channel push-button conditioner: 2-FF synchroniser, stable-count debouncer,
// press/release edge pulses and a per-channel hold FSM for long-press and auto-repeat.
module push_button_bank #(
    parameter int unsigned N             = 4,
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned LONG_CYCLES   = 16,
    parameter int unsigned REPEAT_CYCLES = 8,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] released,
    output logic [N-1:0] long_press,
    output logic [N-1:0] rpt
);

    localparam int unsigned DW   = $clog2(DEB_CYCLES);
    localparam int unsigned HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_e;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          s1_q, s2_q;
        logic          level_q, level_d;
        logic [DW-1:0] deb_q, deb_d;
        hold_e         state_q, state_d;
        logic [HW-1:0] hold_q, hold_d, hold_inc;
        logic          press_q, press_d, rel_q, rel_d;
        logic          long_q, long_d, rpt_q, rpt_d;
        logic          toggle;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                level_q <= 1'b0;
                deb_q   <= '0;
                state_q <= IDLE;
                hold_q  <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                s1_q    <= x[i];
                s2_q    <= s1_q;
                level_q <= level_d;
                deb_q   <= deb_d;
                state_q <= state_d;
                hold_q  <= hold_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                rpt_q   <= rpt_d;
            end
        end

        always_comb begin
            level_d  = level_q;
            deb_d    = '0;
            state_d  = state_q;
            hold_d   = hold_q;
            hold_inc = hold_q + HW'(1);
            press_d  = 1'b0;
            rel_d    = 1'b0;
            long_d   = 1'b0;
            rpt_d    = 1'b0;
            toggle   = 1'b0;

            // Debounce: accept the new level only after DEB_CYCLES consecutive mismatches.
            if (s2_q != level_q) begin
                if (deb_q == DW'(DEB_CYCLES - 1)) begin
                    toggle  = 1'b1;
                    level_d = ~level_q;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end

            // Edge events take priority over hold thresholds, so release beats long/rpt.
            if (toggle && !level_q) begin
                press_d = 1'b1;
                state_d = HELD;
                hold_d  = '0;
            end else if (toggle && level_q) begin
                rel_d   = 1'b1;
                state_d = IDLE;
                hold_d  = '0;
            end else begin
                case (state_q)
                    HELD: begin
                        if (hold_inc == HW'(LONG_CYCLES)) begin
                            long_d  = 1'b1;
                            state_d = LONG;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                    LONG: begin
                        if (REPEAT_EN) begin
                            if (hold_inc == HW'(REPEAT_CYCLES)) begin
                                rpt_d  = 1'b1;
                                hold_d = '0;
                            end else begin
                                hold_d = hold_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign level[i]      = level_q;
        assign press[i]      = press_q;
        assign released[i]   = rel_q;
        assign long_press[i] = long_q;
        assign rpt[i]        = rpt_q;
    end

endmodule

// File: tb/tb_push_button_bank.sv
// Randomised bench for push_button_bank: two instances (repeat on/off) against a
// window-based behavioural model of debounce and press-relative hold timing.
module tb_push_button_bank;

    localparam int unsigned N    = 4;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 16;
    localparam int unsigned REP  = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] x;
    logic [N-1:0] level, press, rel, long_press, rpt;
    logic [N-1:0] level_n, press_n, rel_n, long_n, rpt_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    push_button_bank #(.N(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
                       .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .x(x), .level(level), .press(press),
        .released(rel), .long_press(long_press), .rpt(rpt));

    push_button_bank #(.N(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
                       .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .x(x), .level(level_n), .press(press_n),
        .released(rel_n), .long_press(long_n), .rpt(rpt_n));

    // Reference model state: recent x samples, debounced level, press timestamps.
    logic [N-1:0] xq[$];
    logic [N-1:0] m_lvl, e_press, e_rel, e_long, e_rpt;
    bit           held[N];
    int           tp[N];
    int           t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        xq.delete();
        for (int j = 0; j < int'(DEB) + 2; j++) xq.push_back('0);
        m_lvl = '0; e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        for (int c = 0; c < int'(N); c++) begin
            held[c] = 1'b0;
            tp[c]   = 0;
        end
        t = 0;
    endtask

    // s2 at this edge is the sample from two edges ago; level flips once the last
    // DEB synchronised samples all disagree with it.
    task automatic model_edge(input logic [N-1:0] xs);
        bit mism;
        int d;
        xq.push_front(xs);
        void'(xq.pop_back());
        t++;
        e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        for (int c = 0; c < int'(N); c++) begin
            mism = 1'b1;
            for (int j = 2; j < int'(DEB) + 2; j++)
                if (xq[j][c] == m_lvl[c]) mism = 1'b0;
            if (mism) begin
                m_lvl[c] = ~m_lvl[c];
                if (m_lvl[c]) begin
                    e_press[c] = 1'b1;
                    held[c]    = 1'b1;
                    tp[c]      = t;
                end else begin
                    e_rel[c] = 1'b1;
                    held[c]  = 1'b0;
                end
            end else if (held[c]) begin
                d = t - tp[c];
                if (d == int'(LONG)) e_long[c] = 1'b1;
                else if (d > int'(LONG) && ((d - int'(LONG)) % int'(REP)) == 0) e_rpt[c] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("level",      32'(level),      32'(m_lvl));
        check("press",      32'(press),      32'(e_press));
        check("release",    32'(rel),        32'(e_rel));
        check("long_press", 32'(long_press), 32'(e_long));
        check("rpt",        32'(rpt),        32'(e_rpt));
        check("nr_level",   32'(level_n),    32'(m_lvl));
        check("nr_press",   32'(press_n),    32'(e_press));
        check("nr_release", 32'(rel_n),      32'(e_rel));
        check("nr_long",    32'(long_n),     32'(e_long));
        check("nr_rpt",     32'(rpt_n),      32'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs"}, 32'({level, press, rel, long_press, rpt}), 32'(0));
        check({tag, "_outs_nr"}, 32'({level_n, press_n, rel_n, long_n, rpt_n}), 32'(0));
    endtask

    // Drive x at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic cycle(input logic [N-1:0] xv);
        x = xv;
        @(posedge clk);
        if (rst) model_edge(xv);
        else     model_reset();
        @(negedge clk);
        compare_all();
    endtask

    logic [N-1:0] cur;
    int           rem[N];
    int           lat;
    int           first_press;

    initial begin
        rst = 1'b0;
        x   = '1;
        model_reset();
        @(negedge clk);
        repeat (3) cycle('1);
        check_zero("reset_hold");

        // Reset release with buttons held: fresh press after the sync+debounce latency.
        rst = 1'b1;
        lat = 0;
        first_press = 0;
        for (int k = 0; k < 30; k++) begin
            cycle('1);
            lat++;
            if (press != '0 && first_press == 0) begin
                first_press = lat;
                check("press_all", 32'(press), 32'hF);
            end
        end
        check("press_latency", 32'(first_press), 32'd6);
        repeat (10) cycle('0);

        // Bounce on channel 0 shorter than the debounce window, then a clean hold.
        for (int k = 0; k < 40; k++) cycle((k / 2) % 2 == 0 ? 4'b0001 : 4'b0000);
        repeat (30) cycle(4'b0001);
        repeat (15) cycle('0);

        // Clean short press on channel 1.
        repeat (10) cycle(4'b0010);
        repeat (15) cycle('0);

        // Long hold with repeats on channel 2.
        repeat (60) cycle(4'b0100);
        repeat (15) cycle('0);

        // Simultaneous press, then drop channel 1 alone mid-hold.
        repeat (30) cycle(4'b1111);
        repeat (30) cycle(4'b1101);
        repeat (15) cycle('0);

        // Asynchronous reset 10 cycles into a held channel 2.
        repeat (16) cycle(4'b0100);
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        repeat (2) cycle(4'b0100);
        rst = 1'b1;
        repeat (40) cycle(4'b0100);
        repeat (15) cycle('0);

        // Randomised per-channel hold/bounce lengths.
        cur = '0;
        for (int c = 0; c < int'(N); c++) rem[c] = 1;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < int'(N); c++) begin
                if (rem[c] == 0) begin
                    cur[c] = ~cur[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                         : int'($urandom_range(6, 70));
                end
                rem[c]--;
            end
            cycle(cur);
        end
        repeat (20) cycle('0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
